// File: rtl/clkdiv_ce_if.sv
// clkdiv_ce_if: ratio request handshake between a requester and the clock divider.
interface clkdiv_ce_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             div_err;
    modport master (output div_in, div_valid, input div_ready, div_err);
    modport slave (input div_in, div_valid, output div_ready, div_err);
endinterface

// File: rtl/clkdiv_ce.sv
// clkdiv_ce: fabric clock divider producing a clock-enable strobe, a balanced square wave
// and a phase count, with period-aligned ratio reprogramming and one-cycle calibration slips.
module clkdiv_ce #(
    parameter int WIDTH       = 8,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             hclkin,
    input  logic             reset,
    input  logic             enable,
    input  logic             calib,
    clkdiv_ce_if.slave       bus,
    output logic             ce,
    output logic             clkout,
    output logic [WIDTH-1:0] phase,
    output logic [WIDTH-1:0] div_cur
);
    logic             calib_q, adv, wrap, accept, legal;
    logic [WIDTH-1:0] pend, phase_n, div_n, half;
    always_comb begin
        adv     = enable & ~(calib & ~calib_q);
        wrap    = adv & (phase == div_cur - WIDTH'(1));
        accept  = bus.div_valid & bus.div_ready;
        legal   = bus.div_in >= WIDTH'(2);
        phase_n = adv ? (wrap ? '0 : phase + WIDTH'(1)) : phase;
        // a ratio accepted in its own wrap cycle bypasses the pending register
        div_n   = wrap ? (~bus.div_ready ? pend : (accept & legal ? bus.div_in : div_cur)) : div_cur;
        half    = (div_n >> 1) + {{(WIDTH-1){1'b0}}, div_n[0]};
    end
    always_ff @(posedge hclkin) begin
        if (reset) begin
            phase         <= '0;
            div_cur       <= WIDTH'(DIV_DEFAULT);
            clkout        <= 1'b1;
            ce            <= 1'b0;
            bus.div_err   <= 1'b0;
            bus.div_ready <= 1'b1;
            pend          <= '0;
            calib_q       <= 1'b0;
        end else begin
            phase         <= phase_n;
            div_cur       <= div_n;
            clkout        <= phase_n < half;
            ce            <= wrap;
            bus.div_err   <= accept & ~legal;
            bus.div_ready <= wrap | (bus.div_ready & ~(accept & legal));
            pend          <= accept & legal ? bus.div_in : pend;
            calib_q       <= calib;
        end
    end
endmodule

// File: tb/tb_clkdiv_ce.sv
// tb_clkdiv_ce: directed and random stimulus for clkdiv_ce checked against a cycle model
// built from the period/phase rules.
module tb_clkdiv_ce;
    localparam int W   = 8;
    localparam int DEF = 4;
    logic hclkin = 1'b0, reset = 1'b1, enable = 1'b0, calib = 1'b0;
    logic ce, clkout;
    logic [W-1:0] phase, div_cur;
    clkdiv_ce_if #(.WIDTH(W)) bus();
    clkdiv_ce #(.WIDTH(W), .DIV_DEFAULT(DEF)) dut (
        .hclkin(hclkin), .reset(reset), .enable(enable), .calib(calib), .bus(bus),
        .ce(ce), .clkout(clkout), .phase(phase), .div_cur(div_cur)
    );
    always #5 hclkin = ~hclkin;
    int total = 0, bad = 0;
    int m_ph = 0, m_d = DEF, m_pend = 0, m_rdy = 1, m_ce = 0, m_err = 0, m_cprev = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic en, input logic cal, input logic dv, input int di);
        int adv, acc, wrp;
        reset = r; enable = en; calib = cal; bus.div_valid = dv; bus.div_in = W'(di);
        @(posedge hclkin);
        if (r) begin
            m_ph = 0; m_d = DEF; m_pend = 0; m_rdy = 1; m_ce = 0; m_err = 0; m_cprev = 0;
        end else begin
            adv = (en && !(cal && !m_cprev)) ? 1 : 0;
            m_cprev = cal ? 1 : 0;
            acc = (dv && m_rdy == 1) ? 1 : 0;
            wrp = (adv == 1 && m_ph == m_d - 1) ? 1 : 0;
            m_err = (acc == 1 && di < 2) ? 1 : 0;
            if (adv == 1) m_ph = (wrp == 1) ? 0 : m_ph + 1;
            if (wrp == 1) begin
                if (m_pend != 0) m_d = m_pend;
                else if (acc == 1 && di >= 2) m_d = di;
                m_pend = 0;
            end else if (acc == 1 && di >= 2) m_pend = di;
            m_rdy = (m_pend == 0) ? 1 : 0;
            m_ce = wrp;
        end
        #1;
        chk("phase", 32'(phase), 32'(m_ph));
        chk("div_cur", 32'(div_cur), 32'(m_d));
        chk("clkout", 32'(clkout), (m_ph < (m_d + 1) / 2) ? 32'd1 : 32'd0);
        chk("ce", 32'(ce), 32'(m_ce));
        chk("div_ready", 32'(bus.div_ready), 32'(m_rdy));
        chk("div_err", 32'(bus.div_err), 32'(m_err));
    endtask
    task automatic run_to(input int t);
        for (int i = 0; i < 300 && m_ph != t; i++) step(0, 1, 0, 0, 0);
        chk("reach_phase", 32'(phase), 32'(t));
    endtask
    initial begin
        bus.div_valid = 1'b0;
        bus.div_in = '0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_clkout", 32'(clkout), 32'd1);
        chk("rst_div", 32'(div_cur), 32'(DEF));
        for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 0);
        run_to(1);
        step(0, 1, 0, 1, 5);
        chk("pend_ready_low", 32'(bus.div_ready), 32'd0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
        chk("div5_applied", 32'(div_cur), 32'd5);
        run_to(2);
        step(0, 1, 0, 1, 1);
        chk("err_pulse", 32'(bus.div_err), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        run_to(m_d - 1);
        step(0, 1, 0, 1, 3);
        chk("wrap_load", 32'(div_cur), 32'd3);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        run_to(1);
        step(0, 1, 0, 1, 4);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        run_to(3);
        step(0, 1, 1, 0, 0);
        chk("calib_hold", 32'(phase), 32'd3);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        run_to(1);
        step(0, 0, 0, 1, 6);
        for (int i = 0; i < 6; i++) step(0, 0, i == 2, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
        run_to(0);
        step(0, 1, 0, 1, 9);
        run_to(2);
        step(1, 1, 1, 1, 7);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_div_mid", 32'(div_cur), 32'(DEF));
        chk("rst_ready", 32'(bus.div_ready), 32'd1);
        chk("rst_ce", 32'(ce), 32'd0);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 99) == 0, ($urandom % 8) != 0, ($urandom % 6) == 0,
                 ($urandom % 4) == 0, int'($urandom_range(0, 11)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
